psg_multi: RTL and testbench
============================

# psg_multi

Parametrised successor to the 16-voice programmable sound generator. It time-multiplexes NUM_CH voices (pulse, saw, triangle, noise) from a byte-addressed attribute RAM and mixes them into saturated signed stereo samples, once per `next_sample` request. New over the previous generation: configurable channel count, per-channel phase-reset (hard sync), saturating mix, and sample-valid, busy and overrun status. It sits between the bus attribute-write path and the audio DAC/FIFO.

## Interface
- NUM_CH, 16: voice count; power of two, 2..32; CH_BITS = log2(NUM_CH).
- OUT_W, 16: output sample width, ≥12.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- attr_addr  in  CH_BITS+2  {channel, byte index}.
- attr_wrdata  in  8  attribute byte.
- attr_write  in  1  attribute write strobe.
- next_sample  in  1  one-cycle frame request.
- left_audio, right_audio  out  OUT_W  signed mixed samples; reset 0.
- sample_valid  out  1  one-cycle pulse when outputs update; reset 0.
- busy  out  1  frame in progress; reset 0.
- overrun  out  1  one-cycle pulse when next_sample is dropped; reset 0.

## Operation
- Attribute bytes per channel:
  - b0/b1: freq[15:0], little-endian.
  - b2: vol[5:0], L en [6], R en [7].
  - b3: pulsewidth[5:0], waveform[7:6] (0 pulse, 1 saw, 2 triangle, 3 noise).
- Writes to b3 set the channel's phase-reset flag; NUM_CH-bit register, all ones after reset.
- Working RAM, per channel: {noise[5:0], phase[16:0]}; not reset.
- Free-running 16-bit LFSR, seed 1; shift-in = bit1^bit2^bit4^bit15; noise value = lfsr[6:1].
- Per-channel calc:
  - Phase update:
    - phase-reset flag set: new phase = 0, new noise = 0, flag cleared.
    - else if L|R: new phase = phase + freq (17-bit wrap).
    - else: new phase = 0.
  - Noise latch: when phase[16]=1 and new phase[16]=0, latch the noise value.
  - Waveform signals:
    - pulse: 0 if phase[16:10] > {0,pw}, else 63.
    - saw: phase[16:11].
    - triangle: phase[16] ? ~phase[15:10] : phase[15:10].
    - noise: stored noise.
  - Contribution = ((signal^0x20) as signed 6b × voltable[vol] 9b unsigned)[14:3], signed 12b. Add to each enabled side.
- Accumulators are 12+CH_BITS bits and never wrap. At frame end each side saturates to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- FSM:
  - IDLE: on next_sample go to FETCH, channel 0, clear accumulators.
  - FETCH: 5 cycles; issue b0..b3, capture data one cycle after each address.
  - CALC: 1 cycle; accumulate and write back working data; then channel+1 → FETCH, or after the last channel → DONE.
  - DONE: latch saturated outputs, pulse sample_valid, go to IDLE.
- next_sample while not in IDLE (busy=1): ignored, overrun pulses.
- Attribute write and flag clear for the same channel in the same cycle: set wins.
- Attribute writes during a frame take effect for any byte not yet fetched.
- Reset mid-frame: FSM to IDLE, outputs and status 0, all phase-reset flags set, so stale working RAM is never audible.

## Timing
- Frame = 6·NUM_CH cycles after the IDLE cycle sampling next_sample, plus 1 DONE cycle.
- sample_valid and the new outputs appear the cycle after DONE, i.e. 6·NUM_CH+2 cycles after the request cycle (98 for NUM_CH=16).
- busy is high from the cycle after the request through DONE.
- Attribute RAM and working RAM have 1-cycle read latency.
- Working RAM writes in the CALC cycle and is readable from the next channel's FETCH.

## Structure
- Package psg_pkg holds:
  - 64-entry volume log table function (0,4,8,12,16,17,…,482,511).
  - Waveform and FSM state enums.
  - Byte-index constants, LFSR seed.
- Sub-module psg_voice_calc: combinational phase, noise and contribution datapath.
- Existing dpram is reused for both RAMs.

## Test plan
- Saw, single voice: ch0 freq 0x1000, vol 63, L+R, saw.
  - Frame 1 → both outputs −2044.
  - Frame 2 → −1917.
  - Pulses arrive 98 cycles after the request.
- Saturation, NUM_CH=32: all voices saw, vol 63, L+R, freshly reset → −32768.
  - Then all pulse, pw 63 → +32767.
- Phase reset: ch0 saw running for 5 frames, then b3 rewritten → next frame output −2044 (phase 0).
- L-only vs disabled: ch1 L-only → right_audio 0.
  - ch2 disabled → its phase stays 0 and contributes nothing.
- Overrun: next_sample 10 cycles into a frame → overrun pulse, sample_valid still at cycle 98, no extra frame.
- Reset mid-frame: rst_n low at cycle 40 → all outputs 0; next frame matches the first-frame values of the saw scenario.

Source files
------------

// File: rtl/psg_pkg.sv
// psg_pkg: shared types and constants for the multi-voice sound generator.
//   - wave_e     : waveform select carried in attribute byte 3 [7:6]
//   - state_e    : frame sequencer states
//   - BYTE_*     : attribute byte indices within a channel
//   - LFSR_SEED  : noise LFSR value after reset
//   - vol_lut()  : 64-entry logarithmic volume curve, 9-bit unsigned
package psg_pkg;

   typedef enum logic [1:0] {
      WAVE_PULSE = 2'd0,
      WAVE_SAW   = 2'd1,
      WAVE_TRI   = 2'd2,
      WAVE_NOISE = 2'd3
   } wave_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CALC,
      ST_DONE
   } state_e;

   localparam logic [1:0]  BYTE_FREQ_LO = 2'd0;
   localparam logic [1:0]  BYTE_FREQ_HI = 2'd1;
   localparam logic [1:0]  BYTE_CTRL    = 2'd2;
   localparam logic [1:0]  BYTE_WAVE    = 2'd3;
   localparam logic [15:0] LFSR_SEED    = 16'h0001;

   // Linear for the first few steps, then roughly 6% per step up to full scale.
   function automatic logic [8:0] vol_lut(input logic [5:0] idx);
      logic [8:0] v;
      case (idx)
         6'd0:  v = 9'd0;    6'd1:  v = 9'd4;    6'd2:  v = 9'd8;    6'd3:  v = 9'd12;
         6'd4:  v = 9'd16;   6'd5:  v = 9'd17;   6'd6:  v = 9'd18;   6'd7:  v = 9'd19;
         6'd8:  v = 9'd20;   6'd9:  v = 9'd21;   6'd10: v = 9'd23;   6'd11: v = 9'd24;
         6'd12: v = 9'd26;   6'd13: v = 9'd27;   6'd14: v = 9'd29;   6'd15: v = 9'd31;
         6'd16: v = 9'd33;   6'd17: v = 9'd35;   6'd18: v = 9'd37;   6'd19: v = 9'd39;
         6'd20: v = 9'd41;   6'd21: v = 9'd44;   6'd22: v = 9'd46;   6'd23: v = 9'd49;
         6'd24: v = 9'd52;   6'd25: v = 9'd55;   6'd26: v = 9'd59;   6'd27: v = 9'd62;
         6'd28: v = 9'd66;   6'd29: v = 9'd70;   6'd30: v = 9'd74;   6'd31: v = 9'd79;
         6'd32: v = 9'd83;   6'd33: v = 9'd88;   6'd34: v = 9'd94;   6'd35: v = 9'd99;
         6'd36: v = 9'd105;  6'd37: v = 9'd112;  6'd38: v = 9'd119;  6'd39: v = 9'd126;
         6'd40: v = 9'd133;  6'd41: v = 9'd141;  6'd42: v = 9'd150;  6'd43: v = 9'd159;
         6'd44: v = 9'd169;  6'd45: v = 9'd179;  6'd46: v = 9'd190;  6'd47: v = 9'd201;
         6'd48: v = 9'd213;  6'd49: v = 9'd226;  6'd50: v = 9'd240;  6'd51: v = 9'd254;
         6'd52: v = 9'd270;  6'd53: v = 9'd286;  6'd54: v = 9'd303;  6'd55: v = 9'd322;
         6'd56: v = 9'd341;  6'd57: v = 9'd362;  6'd58: v = 9'd384;  6'd59: v = 9'd407;
         6'd60: v = 9'd431;  6'd61: v = 9'd457;  6'd62: v = 9'd482;  default: v = 9'd511;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/dpram.sv
// dpram: simple dual-port RAM, one write port and one registered read port.
//   clk   : clock
//   we    : write enable; waddr/wdata : write address/data
//   raddr : read address; rdata : data one cycle after raddr (old data on collision)
module dpram #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [1 << AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/psg_voice_calc.sv
// psg_voice_calc: combinational per-voice datapath.
//   freq, ctrl, wave_cfg : attribute bytes {b1,b0}, b2, b3 of the channel
//   phase, noise         : stored working state of the channel
//   phase_rst            : hard-sync flag for the channel
//   lfsr_noise           : current noise sample from the shared LFSR
//   new_phase, new_noise : working state to write back
//   contrib              : signed 12-bit mix contribution
//   en_l, en_r           : side enables
module psg_voice_calc
   import psg_pkg::*;
(
   input  logic [15:0]        freq,
   input  logic [7:0]         ctrl,
   input  logic [7:0]         wave_cfg,
   input  logic [16:0]        phase,
   input  logic [5:0]         noise,
   input  logic               phase_rst,
   input  logic [5:0]         lfsr_noise,
   output logic [16:0]        new_phase,
   output logic [5:0]         new_noise,
   output logic signed [11:0] contrib,
   output logic               en_l,
   output logic               en_r
);

   wave_e              wave;
   logic [5:0]         signal;
   logic signed [5:0]  sig_s;
   logic signed [9:0]  vol_s;
   logic signed [15:0] prod;

   always_comb begin
      en_l = ctrl[6];
      en_r = ctrl[7];

      if (phase_rst) begin
         new_phase = '0;
         new_noise = '0;
      end else begin
         new_phase = (en_l | en_r) ? (phase + {1'b0, freq}) : '0;
         // Refresh noise on each wrap of the phase accumulator.
         new_noise = (phase[16] && !new_phase[16]) ? lfsr_noise : noise;
      end

      // Waveform is taken from the updated state so a synced voice starts at phase 0.
      wave = wave_e'(wave_cfg[7:6]);
      case (wave)
         WAVE_PULSE: signal = (new_phase[16:10] > {1'b0, wave_cfg[5:0]}) ? 6'd0 : 6'd63;
         WAVE_SAW:   signal = new_phase[16:11];
         WAVE_TRI:   signal = new_phase[16] ? ~new_phase[15:10] : new_phase[15:10];
         default:    signal = new_noise;
      endcase

      // Offset-binary to two's complement, scale, keep bits [14:3].
      sig_s   = $signed(signal ^ 6'h20);
      vol_s   = $signed({1'b0, vol_lut(ctrl[5:0])});
      prod    = 16'(sig_s) * 16'(vol_s);
      contrib = 12'(prod >>> 3);
   end

endmodule

// File: rtl/psg_multi.sv
// psg_multi: time-multiplexed NUM_CH-voice sound generator with stereo mix.
//   clk, rst_n          : clock, synchronous active-low reset
//   attr_addr/wrdata/write : attribute byte write port {channel, byte}
//   next_sample         : one-cycle frame request
//   left/right_audio    : saturated signed samples, updated with sample_valid
//   sample_valid        : one-cycle pulse when outputs update
//   busy                : frame in progress
//   overrun             : one-cycle pulse when a request arrives while busy
module psg_multi
   import psg_pkg::*;
#(
   parameter int NUM_CH = 16,
   parameter int OUT_W  = 16,
   localparam int CH_BITS = $clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CH_BITS+1:0]   attr_addr,
   input  logic [7:0]           attr_wrdata,
   input  logic                 attr_write,
   input  logic                 next_sample,
   output logic [OUT_W-1:0]     left_audio,
   output logic [OUT_W-1:0]     right_audio,
   output logic                 sample_valid,
   output logic                 busy,
   output logic                 overrun
);

   localparam int ACC_W   = 12 + CH_BITS;
   localparam int SAT_MAX = 2 ** (OUT_W - 1) - 1;
   localparam int SAT_MIN = -(2 ** (OUT_W - 1));

   state_e                  state_q, state_d;
   logic [CH_BITS-1:0]      chan_q, chan_d;
   logic [2:0]              fcnt_q, fcnt_d;
   logic [7:0]              byte_q [4];
   logic [7:0]              byte_d [4];
   logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [NUM_CH-1:0]       sync_q, sync_d;
   logic [15:0]             lfsr_q, lfsr_d;
   logic [OUT_W-1:0]        left_q, left_d, right_q, right_d;
   logic                    valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;

   logic [7:0]              attr_rdata;
   logic [22:0]             wram_rdata;
   logic [16:0]             new_phase;
   logic [5:0]              new_noise;
   logic signed [11:0]      contrib;
   logic                    en_l, en_r;
   logic signed [ACC_W-1:0] contrib_x;

   function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
      logic signed [31:0] w;
      w = 32'(a);
      if (w > SAT_MAX) return OUT_W'(SAT_MAX);
      if (w < SAT_MIN) return OUT_W'(SAT_MIN);
      return OUT_W'(w);
   endfunction

   dpram #(.AW(CH_BITS + 2), .DW(8)) u_attr_ram (
      .clk   (clk),
      .we    (attr_write),
      .waddr (attr_addr),
      .wdata (attr_wrdata),
      .raddr ({chan_q, fcnt_q[1:0]}),
      .rdata (attr_rdata)
   );

   dpram #(.AW(CH_BITS), .DW(23)) u_work_ram (
      .clk   (clk),
      .we    (state_q == ST_CALC),
      .waddr (chan_q),
      .wdata ({new_noise, new_phase}),
      .raddr (chan_q),
      .rdata (wram_rdata)
   );

   psg_voice_calc u_calc (
      .freq       ({byte_q[1], byte_q[0]}),
      .ctrl       (byte_q[2]),
      .wave_cfg   (byte_q[3]),
      .phase      (wram_rdata[16:0]),
      .noise      (wram_rdata[22:17]),
      .phase_rst  (sync_q[chan_q]),
      .lfsr_noise (lfsr_q[6:1]),
      .new_phase  (new_phase),
      .new_noise  (new_noise),
      .contrib    (contrib),
      .en_l       (en_l),
      .en_r       (en_r)
   );

   always_comb begin
      state_d   = state_q;
      chan_d    = chan_q;
      fcnt_d    = fcnt_q;
      byte_d    = byte_q;
      acc_l_d   = acc_l_q;
      acc_r_d   = acc_r_q;
      sync_d    = sync_q;
      left_d    = left_q;
      right_d   = right_q;
      valid_d   = 1'b0;
      contrib_x = ACC_W'(contrib);
      lfsr_d    = {lfsr_q[14:0], lfsr_q[1] ^ lfsr_q[2] ^ lfsr_q[4] ^ lfsr_q[15]};
      ovr_d     = next_sample && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (next_sample) begin
               state_d = ST_FETCH;
               chan_d  = '0;
               fcnt_d  = '0;
               acc_l_d = '0;
               acc_r_d = '0;
            end
         end
         ST_FETCH: begin
            // Byte k was addressed in fetch step k and is captured in step k+1.
            if (fcnt_q != 3'd0) begin
               byte_d[2'(fcnt_q - 3'd1)] = attr_rdata;
            end
            if (fcnt_q == 3'd4) begin
               state_d = ST_CALC;
            end else begin
               fcnt_d = fcnt_q + 3'd1;
            end
         end
         ST_CALC: begin
            if (en_l) acc_l_d = acc_l_q + contrib_x;
            if (en_r) acc_r_d = acc_r_q + contrib_x;
            sync_d[chan_q] = 1'b0;
            if (chan_q == CH_BITS'(NUM_CH - 1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FETCH;
               chan_d  = chan_q + 1'b1;
               fcnt_d  = '0;
            end
         end
         default: begin
            left_d  = saturate(acc_l_q);
            right_d = saturate(acc_r_q);
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
      endcase

      // A host write to the waveform byte re-arms hard sync; it overrides the CALC clear.
      if (attr_write && (attr_addr[1:0] == BYTE_WAVE)) begin
         sync_d[attr_addr[CH_BITS+1:2]] = 1'b1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         chan_q  <= '0;
         fcnt_q  <= '0;
         byte_q  <= '{default: '0};
         acc_l_q <= '0;
         acc_r_q <= '0;
         sync_q  <= '1;
         lfsr_q  <= LFSR_SEED;
         left_q  <= '0;
         right_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         fcnt_q  <= fcnt_d;
         byte_q  <= byte_d;
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
         sync_q  <= sync_d;
         lfsr_q  <= lfsr_d;
         left_q  <= left_d;
         right_q <= right_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end
   end

   assign left_audio   = left_q;
   assign right_audio  = right_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_psg_multi.sv
// tb_psg_multi: directed bench for psg_multi, one 16-voice and one 32-voice instance.
module tb_psg_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 16-voice instance
   logic               rst_n, attr_write, next_sample;
   logic [5:0]         attr_addr;
   logic [7:0]         attr_wrdata;
   logic signed [15:0] left_a, right_a;
   logic               sample_valid, busy, overrun;

   // 32-voice instance
   logic               rst_n_b, attr_write_b, next_sample_b;
   logic [6:0]         attr_addr_b;
   logic [7:0]         attr_wrdata_b;
   logic signed [15:0] left_b, right_b;
   logic               sample_valid_b, busy_b, overrun_b;

   int n_checks = 0;
   int n_fail   = 0;

   psg_multi #(.NUM_CH(16), .OUT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .attr_addr    (attr_addr),
      .attr_wrdata  (attr_wrdata),
      .attr_write   (attr_write),
      .next_sample  (next_sample),
      .left_audio   (left_a),
      .right_audio  (right_a),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   psg_multi #(.NUM_CH(32), .OUT_W(16)) dut32 (
      .clk          (clk),
      .rst_n        (rst_n_b),
      .attr_addr    (attr_addr_b),
      .attr_wrdata  (attr_wrdata_b),
      .attr_write   (attr_write_b),
      .next_sample  (next_sample_b),
      .left_audio   (left_b),
      .right_audio  (right_b),
      .sample_valid (sample_valid_b),
      .busy         (busy_b),
      .overrun      (overrun_b)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wr16(input logic [5:0] a, input logic [7:0] d);
      attr_addr   = a;
      attr_wrdata = d;
      attr_write  = 1'b1;
      @(negedge clk);
      attr_write  = 1'b0;
   endtask

   task automatic wr32(input logic [6:0] a, input logic [7:0] d);
      attr_addr_b   = a;
      attr_wrdata_b = d;
      attr_write_b  = 1'b1;
      @(negedge clk);
      attr_write_b  = 1'b0;
   endtask

   // Leaves the caller at the negedge of the first busy cycle (cycle 1 after request).
   task automatic request16();
      next_sample = 1'b1;
      @(negedge clk);
      next_sample = 1'b0;
   endtask

   task automatic wait_valid16(input int start, output int lat);
      lat = start;
      while (!sample_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic frame16(input string tag, input int exp_l, input int exp_r);
      int lat;
      request16();
      check({tag, "_busy"}, int'(busy), 1);
      wait_valid16(1, lat);
      check({tag, "_lat"}, lat, 98);
      check({tag, "_left"}, int'(left_a), exp_l);
      check({tag, "_right"}, int'(right_a), exp_r);
      @(negedge clk);
      check({tag, "_vpulse"}, int'(sample_valid), 0);
   endtask

   task automatic frame32(input string tag, input int exp_l, input int exp_r);
      int lat;
      next_sample_b = 1'b1;
      @(negedge clk);
      next_sample_b = 1'b0;
      lat = 1;
      while (!sample_valid_b && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, 194);
      check({tag, "_left"}, int'(left_b), exp_l);
      check({tag, "_right"}, int'(right_b), exp_r);
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int extra;
      rst_n = 1'b0;        rst_n_b = 1'b0;
      attr_write = 1'b0;   attr_write_b = 1'b0;
      next_sample = 1'b0;  next_sample_b = 1'b0;
      attr_addr = '0;      attr_addr_b = '0;
      attr_wrdata = '0;    attr_wrdata_b = '0;
      repeat (3) @(negedge clk);

      check("rst_left",    int'(left_a), 0);
      check("rst_right",   int'(right_a), 0);
      check("rst_valid",   int'(sample_valid), 0);
      check("rst_busy",    int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      rst_n_b = 1'b1;
      @(negedge clk);

      for (int a = 0; a < 64; a++) wr16(6'(a), 8'h00);

      // ch0 saw, freq 0x1000, vol 63, L+R
      wr16(6'd0, 8'h00); wr16(6'd1, 8'h10); wr16(6'd2, 8'hFF); wr16(6'd3, 8'h40);
      frame16("saw_f1", -2044, -2044);
      frame16("saw_f2", -1917, -1917);
      frame16("saw_f3", -1789, -1789);
      frame16("saw_f4", -1661, -1661);
      frame16("saw_f5", -1533, -1533);

      // hard sync by rewriting the waveform byte
      wr16(6'd3, 8'h40);
      frame16("sync_f1", -2044, -2044);
      frame16("sync_f2", -1917, -1917);

      // ch0 off; ch1 triangle L-only freq 0x8000; ch2 saw with no side enabled
      wr16(6'd2, 8'h00);
      wr16(6'd4, 8'h00); wr16(6'd5, 8'h80); wr16(6'd6, 8'h7F); wr16(6'd7, 8'h80);
      wr16(6'd8, 8'h34); wr16(6'd9, 8'h12); wr16(6'd10, 8'h3F); wr16(6'd11, 8'h40);
      frame16("tri_f1", -2044, 0);
      frame16("tri_f2", 0, 0);
      frame16("tri_f3", 1980, 0);
      frame16("tri_f4", -64, 0);

      // ch1 off, enable ch2: its phase must have stayed 0 while disabled
      wr16(6'd6, 8'h00);
      wr16(6'd10, 8'hFF);
      frame16("ch2_f1", -1917, -1917);

      // request 10 cycles into a frame is dropped
      request16();
      repeat (9) @(negedge clk);
      next_sample = 1'b1;
      @(negedge clk);
      next_sample = 1'b0;
      check("ovr_pulse", int'(overrun), 1);
      wait_valid16(11, lat);
      check("ovr_lat", lat, 98);
      check("ovr_left", int'(left_a), -1789);
      @(negedge clk);
      check("ovr_clear", int'(overrun), 0);
      extra = 0;
      for (int i = 0; i < 150; i++) begin
         if (sample_valid) extra++;
         @(negedge clk);
      end
      check("ovr_no_extra_frame", extra, 0);
      check("ovr_idle", int'(busy), 0);

      // reset at cycle 40 of a frame
      request16();
      repeat (39) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_left",  int'(left_a), 0);
      check("mid_rst_right", int'(right_a), 0);
      check("mid_rst_busy",  int'(busy), 0);
      check("mid_rst_valid", int'(sample_valid), 0);
      rst_n = 1'b1;
      extra = 0;
      for (int i = 0; i < 120; i++) begin
         if (sample_valid) extra++;
         @(negedge clk);
      end
      check("mid_rst_quiet", extra, 0);
      frame16("post_rst_f1", -2044, -2044);
      frame16("post_rst_f2", -1917, -1917);

      // 32 voices saturating both ways
      for (int ch = 0; ch < 32; ch++) begin
         wr32({5'(ch), 2'd0}, 8'h00);
         wr32({5'(ch), 2'd1}, 8'h00);
         wr32({5'(ch), 2'd2}, 8'hFF);
         wr32({5'(ch), 2'd3}, 8'h40);
      end
      frame32("sat_neg", -32768, -32768);
      for (int ch = 0; ch < 32; ch++) wr32({5'(ch), 2'd3}, 8'h3F);
      frame32("sat_pos", 32767, 32767);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
